// File: rtl/baud_pkg.sv
// baud_pkg: shared constants, helpers and state type for the baud tick generator.
//   CLK_HZ      nominal system clock (12 MHz)
//   DIV_*       ready-made divisors for common baud rates at CLK_HZ
//   baud_div()  rounded clk-cycles-per-bit for an arbitrary clock/baud pair
//   baud_state_e  IDLE / RUN
package baud_pkg;

  localparam int unsigned CLK_HZ     = 12000000;
  localparam int unsigned DIV_9600   = 1250;
  localparam int unsigned DIV_19200  = 625;
  localparam int unsigned DIV_115200 = 104;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } baud_state_e;

  // Round to nearest: adding half the baud rate before dividing.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    if (baud == 0) begin
      return 0;
    end
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/baud_ovs_acc.sv
// baud_ovs_acc: fractional accumulator producing OVS evenly spread pulses per
// bit period of `div` clock cycles.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   run         accumulate this cycle; low clears the accumulator and the tick
//   clr         clear the accumulator at this edge (bit wrap); tick still decided
//   div         current divisor (cycles per bit), assumed >= OVS
//   tick        registered one-cycle oversampling pulse
module baud_ovs_acc #(
  parameter int DIV_W = 16,
  parameter int OVS   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  localparam logic [DIV_W:0] OVS_STEP = (DIV_W+1)'(OVS);

  // One extra bit: acc < div and OVS <= div, so acc + OVS < 2*div fits.
  logic [DIV_W:0] acc_reg;
  logic [DIV_W:0] acc_next;
  logic [DIV_W:0] sum;
  logic [DIV_W:0] div_ext;
  logic           tick_reg;
  logic           tick_next;

  assign div_ext = {1'b0, div};

  always_comb begin
    sum       = acc_reg + OVS_STEP;
    acc_next  = '0;
    tick_next = 1'b0;
    if (run) begin
      if (sum >= div_ext) begin
        tick_next = 1'b1;
        acc_next  = sum - div_ext;
      end else begin
        acc_next  = sum;
      end
      // At the bit wrap the accumulator is already back at zero for a
      // consistent divisor; clearing keeps phase exact across divisor changes.
      if (clr) begin
        acc_next = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      acc_reg  <= acc_next;
      tick_reg <= tick_next;
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: runtime-programmable baud tick generator.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   enable      run request; low returns to IDLE and clears the bit counter
//   restart     realign phase: bit counter and accumulator restart at 0
//   div_in      new divisor (clk cycles per bit), clamped to >= max(OVS,2)
//   div_load    one-cycle strobe capturing div_in as the pending divisor
//   tick_mid    pulse at mid-bit (cnt == div_cur>>1)
//   tick_end    pulse on the last cycle of each bit
//   tick_ovs    OVS evenly spread pulses per bit
//   running     high while in RUN
//   div_cur     divisor currently in effect
//   div_err     (only when BAUD_ERR_EN is defined) sticky "last load was clamped"
// A pending divisor is applied only at a bit boundary (wrap, restart) or while
// idle, so a bit is never shortened or stretched. DEF_DIV is expected >= OVS.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = DIV_9600,
  parameter int OVS     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             restart,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  output logic             tick_mid,
  output logic             tick_end,
  output logic             tick_ovs,
  output logic             running,
  output logic [DIV_W-1:0] div_cur
`ifdef BAUD_ERR_EN
  ,
  output logic             div_err
`endif
);

  localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'((OVS > 2) ? OVS : 2);
  localparam logic [DIV_W-1:0] RST_DIV  = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);

  baud_state_e      state_reg, state_next;
  logic [DIV_W-1:0] cnt_reg, cnt_next;
  logic [DIV_W-1:0] div_cur_reg, div_cur_next;
  logic [DIV_W-1:0] div_pend_reg, div_pend_next;
  logic             pend_v_reg, pend_v_next;
  logic             run_st;
  logic             wrap;
  logic             apply_pend;
  logic [DIV_W-1:0] div_clamped;

  assign run_st      = (state_reg == RUN);
  assign wrap        = run_st && (cnt_reg == div_cur_reg - CNT_ONE);
  assign div_clamped = (div_in < MIN_DIV) ? MIN_DIV : div_in;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    div_cur_next  = div_cur_reg;
    div_pend_next = div_pend_reg;
    pend_v_next   = pend_v_reg;
    apply_pend    = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next   = '0;
        apply_pend = 1'b1;
        if (enable) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          // Abandon the bit in progress; the pending divisor waits for IDLE.
          state_next = IDLE;
          cnt_next   = '0;
        end else if (restart || wrap) begin
          cnt_next   = '0;
          apply_pend = 1'b1;
        end else begin
          cnt_next   = cnt_reg + CNT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Apply the old pending value first so that a load on the same edge
    // stays pending for the next boundary.
    if (apply_pend && pend_v_reg) begin
      div_cur_next = div_pend_reg;
      pend_v_next  = 1'b0;
    end
    if (div_load) begin
      div_pend_next = div_clamped;
      pend_v_next   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      div_cur_reg  <= RST_DIV;
      div_pend_reg <= RST_DIV;
      pend_v_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      div_cur_reg  <= div_cur_next;
      div_pend_reg <= div_pend_next;
      pend_v_reg   <= pend_v_next;
    end
  end

  // The accumulator only advances on edges where RUN continues without a
  // realign, so leaving RUN or restarting never emits a stray tick_ovs.
  baud_ovs_acc #(
    .DIV_W (DIV_W),
    .OVS   (OVS)
  ) u_ovs_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run_st && enable && !restart),
    .clr   (wrap),
    .div   (div_cur_reg),
    .tick  (tick_ovs)
  );

  assign tick_mid = run_st && (cnt_reg == (div_cur_reg >> 1));
  assign tick_end = wrap;
  assign running  = run_st;
  assign div_cur  = div_cur_reg;

`ifdef BAUD_ERR_EN
  logic div_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_err_reg <= 1'b0;
    end else if (div_load) begin
      div_err_reg <= (div_in < MIN_DIV);
    end
  end

  assign div_err = div_err_reg;
`endif

endmodule

// File: tb/tb_baud_tick_gen.sv
`timescale 1ns/1ps
module tb_baud_tick_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // DUT A: default OVS=16
  logic        enable = 1'b0, restart = 1'b0, div_load = 1'b0;
  logic [15:0] div_in = '0;
  logic        tick_mid, tick_end, tick_ovs, running;
  logic [15:0] div_cur;
  // DUT B: OVS=2 for the odd-divisor case
  logic        en2 = 1'b0, rs2 = 1'b0, ld2 = 1'b0;
  logic [15:0] div_in2 = '0;
  logic        mid2, end2, ovs2, run2;
  logic [15:0] div2;
`ifdef BAUD_ERR_EN
  logic        div_err, div_err2;
`endif

  always #5 clk = ~clk;

  baud_tick_gen dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
    .div_in(div_in), .div_load(div_load),
    .tick_mid(tick_mid), .tick_end(tick_end), .tick_ovs(tick_ovs),
    .running(running), .div_cur(div_cur)
`ifdef BAUD_ERR_EN
    , .div_err(div_err)
`endif
  );

  baud_tick_gen #(.OVS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(en2), .restart(rs2),
    .div_in(div_in2), .div_load(ld2),
    .tick_mid(mid2), .tick_end(end2), .tick_ovs(ovs2),
    .running(run2), .div_cur(div2)
`ifdef BAUD_ERR_EN
    , .div_err(div_err2)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0; restart = 1'b0; div_load = 1'b0;
    en2 = 1'b0; rs2 = 1'b0; ld2 = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  typedef struct {
    logic [15:0] div_in;
    int exp_div;
    int exp_mid;
    int exp_end;
    int exp_ovs;
    int exp_gmin;
    int exp_gmax;
    int exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int m0, m1, e0, e1, ovs_n, last, gmin, gmax, d, m, e_cnt, cnt3;

    vecs[0] = '{16'd1250, 1250, 625, 1249, 16, 78, 79, 0};
    vecs[1] = '{16'd104,  104,  52,  103,  16, 6,  7,  0};
    vecs[2] = '{16'd625,  625,  312, 624,  16, 39, 40, 0};
    vecs[3] = '{16'd5,    16,   8,   15,   16, 1,  1,  1};
    vecs[4] = '{16'd17,   17,   8,   16,   16, 1,  2,  0};
    vecs[5] = '{16'd0,    16,   8,   15,   16, 1,  1,  1};

    // ---- reset state ----
    rst_n = 1'b0;
    step();
    check("rst_running", running, 0);
    check("rst_tick_mid", tick_mid, 0);
    check("rst_tick_end", tick_end, 0);
    check("rst_tick_ovs", tick_ovs, 0);
    check("rst_div_cur", div_cur, 1250);
`ifdef BAUD_ERR_EN
    check("rst_div_err", div_err, 0);
`endif
    $display("reset: running=%0d div_cur=%0d", running, div_cur);

    // ---- table: load divisor while idle, then enable and measure ----
    for (int i = 0; i < 6; i++) begin
      do_reset();
      div_in = vecs[i].div_in; div_load = 1'b1;
      step();
      div_load = 1'b0;
      step();
      check($sformatf("v%0d_div_cur", i), div_cur, vecs[i].exp_div);
`ifdef BAUD_ERR_EN
      check($sformatf("v%0d_div_err", i), div_err, vecs[i].exp_err);
`endif
      enable = 1'b1;
      step();  // E0
      check($sformatf("v%0d_running", i), running, 1);
      d = vecs[i].exp_div;
      m0 = -1; m1 = -1; e0 = -1; e1 = -1; ovs_n = 0; last = -1; gmin = 1000000; gmax = 0;
      for (int k = 1; k <= 2 * d + 2; k++) begin
        step();
        if (tick_mid) begin
          if (m0 < 0) m0 = k; else if (m1 < 0) m1 = k;
        end
        if (tick_end) begin
          if (e0 < 0) e0 = k; else if (e1 < 0) e1 = k;
        end
        if (tick_ovs) begin
          if (k <= d) ovs_n++;
          if (last >= 0) begin
            if (k - last < gmin) gmin = k - last;
            if (k - last > gmax) gmax = k - last;
          end
          last = k;
        end
      end
      check($sformatf("v%0d_first_mid", i), m0, vecs[i].exp_mid);
      check($sformatf("v%0d_first_end", i), e0, vecs[i].exp_end);
      check($sformatf("v%0d_mid_period", i), m1 - m0, d);
      check($sformatf("v%0d_end_period", i), e1 - e0, d);
      check($sformatf("v%0d_ovs_per_bit", i), ovs_n, vecs[i].exp_ovs);
      check($sformatf("v%0d_ovs_gap_min", i), gmin, vecs[i].exp_gmin);
      check($sformatf("v%0d_ovs_gap_max", i), gmax, vecs[i].exp_gmax);
      $display("vec %0d: div_in=%0d div_cur=%0d mid=%0d end=%0d ovs=%0d gaps=%0d..%0d",
               i, vecs[i].div_in, div_cur, m0, e0, ovs_n, gmin, gmax);
    end

`ifdef BAUD_ERR_EN
    // ---- sticky error cleared only by a legal load ----
    div_in = 16'd5; div_load = 1'b1; step(); div_load = 1'b0; step();
    check("err_set", div_err, 1);
    repeat (3) step();
    check("err_sticky", div_err, 1);
    div_in = 16'd625; div_load = 1'b1; step(); div_load = 1'b0; step();
    check("err_clear", div_err, 0);
    $display("div_err sequence: final div_err=%0d", div_err);
`endif

    // ---- divisor load mid-bit ----
    do_reset();
    enable = 1'b1;
    step();  // E0
    repeat (300) step();  // cnt=300
    div_in = 16'd104; div_load = 1'b1;
    step();
    div_load = 1'b0;
    m = -1; e_cnt = -1;
    for (int k = 302; k <= 1400; k++) begin
      step();
      if (k == 1249) begin
        check("load_old_div_before_wrap", div_cur, 1250);
        check("load_end_at_1249", tick_end, 1);
      end
      if (k == 1250) check("load_new_div_after_wrap", div_cur, 104);
      if (k > 1250 && tick_mid && m < 0) m = k;
      if (k > 1250 && tick_end && e_cnt < 0) e_cnt = k;
    end
    check("load_new_mid", m, 1302);
    check("load_new_end", e_cnt, 1353);
    $display("mid-bit load: new mid at %0d, new end at %0d", m, e_cnt);

    // ---- disable mid-bit, re-enable, async reset mid-bit ----
    do_reset();
    enable = 1'b1;
    step();
    repeat (700) step();
    enable = 1'b0;
    step();
    check("dis_running", running, 0);
    check("dis_tick_mid", tick_mid, 0);
    check("dis_tick_end", tick_end, 0);
    check("dis_tick_ovs", tick_ovs, 0);
    cnt3 = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      cnt3 += int'(tick_mid) + int'(tick_end) + int'(tick_ovs);
    end
    check("idle_no_ticks", cnt3, 0);
    enable = 1'b1;
    step();  // E0'
    m = -1;
    for (int k = 1; k <= 700 && m < 0; k++) begin
      step();
      if (tick_mid) m = k;
    end
    check("reen_mid_lead", m, 625);
    check("pre_reset_mid", tick_mid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_mid", tick_mid, 0);
    check("async_rst_running", running, 0);
    check("async_rst_ovs", tick_ovs, 0);
    check("async_rst_end", tick_end, 0);
    step();
    rst_n = 1'b1;
    $display("disable/reset: re-enable mid lead=%0d", m);

    // ---- restart ----
    do_reset();
    enable = 1'b1;
    step();
    repeat (900) step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    m = -1; e_cnt = 0;
    for (int k = 1; k <= 700; k++) begin
      step();
      if (tick_mid && m < 0) m = k;
      if (tick_end) e_cnt++;
    end
    check("restart_mid_lead", m, 625);
    check("restart_no_old_end", e_cnt, 0);
    div_in = 16'd104; div_load = 1'b1;
    step();
    div_load = 1'b0;
    step();
    check("restart_pend_not_yet", div_cur, 1250);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("restart_applies_pend", div_cur, 104);
    m = -1;
    for (int k = 1; k <= 60 && m < 0; k++) begin
      step();
      if (tick_mid) m = k;
    end
    check("restart_new_mid_lead", m, 52);
    restart = 1'b1; enable = 1'b0;
    step();
    restart = 1'b0;
    check("restart_dis_running", running, 0);
    repeat (3) step();
    check("restart_dis_stays_idle", running, 0);
    $display("restart: mid lead=%0d div_cur=%0d", m, div_cur);

    // ---- odd divisor on OVS=2 instance ----
    do_reset();
    div_in2 = 16'd3; ld2 = 1'b1;
    step();
    ld2 = 1'b0;
    step();
    check("odd_div_cur", div2, 3);
    en2 = 1'b1;
    step();
    cnt3 = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("odd_mid_k%0d", k), mid2, (k % 3 == 1) ? 1 : 0);
      check($sformatf("odd_end_k%0d", k), end2, (k % 3 == 2) ? 1 : 0);
      check($sformatf("odd_ovs_k%0d", k), ovs2, (k % 3 != 1) ? 1 : 0);
      cnt3 += int'(ovs2);
    end
    check("odd_ovs_total", cnt3, 6);
    $display("odd divisor: div_cur=%0d ovs in 9 cycles=%0d", div2, cnt3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
